// File: rtl/data_memory_if.sv
// Bus between a requester and data_memory: byte address, write data/enable, read data, error.
interface data_memory_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       Addr;
    logic [DATA_W-1:0] Write;
    logic [DATA_W-1:0] Read;
    logic              WE;
    logic              err;

    modport master (output Addr, output Write, output WE, input Read, input err);
    modport slave  (input Addr, input Write, input WE, output Read, output err);
endinterface

// File: rtl/data_memory.sv
// Word-addressed RAM with combinational read, synchronous write and synchronous clear-all reset.
// Define DATA_MEMORY_ACCESS_CHECK_EN to flag and suppress misaligned or out-of-range accesses.
module data_memory #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]   idx;
    logic              in_range;
    logic              misaligned;
    logic              wr_en;

    assign idx        = bus.Addr[IdxW+1:2];
    // Everything above the word index must be zero for the address to be below 4*DEPTH.
    assign in_range   = (bus.Addr[31:IdxW+2] == '0);
    assign misaligned = (bus.Addr[1:0] != 2'b00);

`ifdef DATA_MEMORY_ACCESS_CHECK_EN
    assign wr_en   = bus.WE && in_range && !misaligned;
    assign bus.err = (bus.WE && misaligned) || !in_range;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign wr_en   = bus.WE && in_range;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        bus.Read = '0;
        if (in_range) begin
            bus.Read = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= bus.Write;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: behavioural model checked every cycle plus literal expectations.
module tb_data_memory;
    localparam int unsigned DEPTH = 64;
`ifdef DATA_MEMORY_ACCESS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic checking;
    int   n_cmp;
    int   n_bad;
    logic [31:0] model [DEPTH];

    data_memory_if #(.DATA_W(32)) bus ();

    data_memory #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= 4 * DEPTH) return 32'h0;
        return model[a / 4];
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic we);
        if (!CHK) return 1'b0;
        return (we && (a % 4 != 0)) || (a >= 4 * DEPTH);
    endfunction

    // Model state advances on the same edge as the DUT; inputs are stable around it.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        end else if (bus.WE && bus.Addr < 4 * DEPTH && (!CHK || bus.Addr % 4 == 0)) begin
            model[bus.Addr / 4] = bus.Write;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_read", bus.Read, model_read(bus.Addr));
            chk("model_err", {31'h0, bus.err}, {31'h0, model_err(bus.Addr, bus.WE)});
        end
    end

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] w);
        bus.WE    = we;
        bus.Addr  = a;
        bus.Write = w;
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        checking = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        edge_then_settle();
        rst_n    = 1'b1;
        checking = 1'b1;

        // Reset state
        chk("reset_read0", bus.Read, 32'h0);
        chk("reset_err", {31'h0, bus.err}, 32'h0);
        drive(1'b0, 32'd96, 32'd0);
        chk("reset_read96", bus.Read, 32'h0);

        // Write/readback
        drive(1'b1, 32'd96, 32'd7);
        edge_then_settle();
        drive(1'b1, 32'd100, 32'd25);
        edge_then_settle();
        drive(1'b0, 32'd96, 32'd0);
        chk("wr_read96", bus.Read, 32'd7);
        drive(1'b0, 32'd100, 32'd0);
        chk("wr_read100", bus.Read, 32'd25);

        // Write disabled
        drive(1'b0, 32'd96, 32'hDEAD_BEEF);
        repeat (3) edge_then_settle();
        chk("we0_read96", bus.Read, 32'd7);

        // Read-during-write: old before, new after
        drive(1'b1, 32'd96, 32'd11);
        chk("rdw_before", bus.Read, 32'd7);
        edge_then_settle();
        chk("rdw_after", bus.Read, 32'd11);

        // Reset overrides a write
        rst_n = 1'b0;
        drive(1'b1, 32'd100, 32'd9);
        edge_then_settle();
        rst_n = 1'b1;
        drive(1'b0, 32'd96, 32'd0);
        chk("rst_read96", bus.Read, 32'h0);
        drive(1'b0, 32'd100, 32'd0);
        chk("rst_read100", bus.Read, 32'h0);

        // Out of range
        drive(1'b1, 32'd0, 32'h55);
        edge_then_settle();
        drive(1'b1, 32'd256, 32'd5);
        chk("oor_read", bus.Read, 32'h0);
        chk("oor_err", {31'h0, bus.err}, {31'h0, CHK});
        edge_then_settle();
        drive(1'b0, 32'd0, 32'd0);
        chk("oor_word0", bus.Read, 32'h55);
        drive(1'b0, 32'hFFFF_FFFC, 32'd0);
        chk("oor_high_read", bus.Read, 32'h0);

        // Top word and byte-offset read
        drive(1'b1, 32'd252, 32'hA5A5_0001);
        edge_then_settle();
        drive(1'b0, 32'd255, 32'd0);
        chk("top_read_off", bus.Read, 32'hA5A5_0001);
        chk("rd_misaligned_err", {31'h0, bus.err}, 32'h0);

        // Misaligned write
        drive(1'b1, 32'd96, 32'd7);
        edge_then_settle();
        drive(1'b1, 32'd98, 32'd3);
        chk("mis_read_before", bus.Read, 32'd7);
        chk("mis_err", {31'h0, bus.err}, {31'h0, CHK});
        edge_then_settle();
        drive(1'b0, 32'd96, 32'd0);
        chk("mis_word96", bus.Read, CHK ? 32'd7 : 32'd3);

        // Write data changing between edges: only the edge value lands
        drive(1'b1, 32'd8, 32'h1111_1111);
        drive(1'b1, 32'd8, 32'h2222_2222);
        edge_then_settle();
        drive(1'b0, 32'd8, 32'h3333_3333);
        edge_then_settle();
        chk("edge_sample", bus.Read, 32'h2222_2222);

        edge_then_settle();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored (power of two, 4..4096).
REQ-002 Parameter DATA_W, default 32, word width in bits; fixed at 32.
REQ-003 The design SHALL have exactly one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock; all state changes occur on this edge.
REQ-005 rst_n  input  1  synchronous reset, active low, sampled on rising clk.
REQ-006 Addr  input  32  byte address of the word to read or write.
REQ-007 Write  input  32  write data.
REQ-008 Read  output  32  read data for Addr.
REQ-009 WE  input  1  write enable, active high.
REQ-010 err  output  1  access-error flag; function defined in Configuration.

Function
REQ-011 Storage SHALL be DEPTH words of 32 bits, indexed by word index = Addr[log2(DEPTH)+1:2].
REQ-012 Addr[1:0] SHALL be ignored for indexing, so accesses are word-aligned by truncation.
REQ-013 An access is in range when Addr < 4*DEPTH; otherwise it is out of range.
REQ-014 Read SHALL be combinational (zero latency): Read = mem[index] when in range, 32'h0 when out of range.
REQ-015 Write SHALL be synchronous: on rising clk with rst_n=1, WE=1 and Addr in range, mem[index] <= Write.
REQ-016 Writes with WE=0 or with Addr out of range SHALL leave memory unchanged.
REQ-017 Read-during-write to the same address SHALL show old data before the edge and new data immediately after it; there is no bypass.
REQ-018 Read SHALL follow Addr changes within the same cycle, with no clock required.
REQ-019 Write and Addr changes between clock edges SHALL have no effect; only values sampled at the rising edge matter.

Reset
REQ-020 On rising clk with rst_n=0, every word SHALL be cleared to 32'h0.
REQ-021 Reset SHALL take priority over WE; a write in a reset cycle is discarded.
REQ-022 After reset, Read SHALL be 32'h0 for all addresses; err SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all prior contents on the first sampled edge.

Configuration
REQ-024 The macro DATA_MEMORY_ACCESS_CHECK_EN SHALL enable access checking.
REQ-025 With the macro defined, err SHALL be combinational and high when (WE=1 and Addr[1:0]!=0) or Addr is out of range.
REQ-026 With the macro defined, misaligned writes SHALL be suppressed.
REQ-027 With the macro undefined, err SHALL be tied to 0.
REQ-028 With the macro undefined, misaligned writes SHALL proceed with truncated indexing.

Verification
REQ-029 Write/readback: reset, then WE=1 with Addr=96, Write=7 for one edge and Addr=100, Write=25 for the next edge, then WE=0 -> Addr=96 reads 7 and Addr=100 reads 25 with no clock edge needed.
REQ-030 Write disabled: with WE=0, Addr=96, Write=32'hDEAD_BEEF over 3 edges -> Read stays 7.
REQ-031 Reset: after the writes, hold rst_n=0 for one edge with WE=1, Addr=100, Write=9 -> Read at 96 and at 100 are both 0.
REQ-032 Read-during-write: holding Addr=96 (contents 7), set WE=1, Write=11 -> Read is 7 before the edge and 11 after it.
REQ-033 Out of range with DEPTH=64: WE=1 at Addr=256, Write=5 -> Read=0, word 0 unchanged, and err=1 only when DATA_MEMORY_ACCESS_CHECK_EN is defined.
REQ-034 Misaligned: WE=1 at Addr=98, Write=3 -> with the macro defined, err=1 and word 96 unchanged; without it, word 96 becomes 3.
